router_out_arbiter: RTL and testbench
=====================================

Name: router_out_arbiter

Overview:
- Round-robin packet scheduler that drains the three destination FIFOs of the 1x3 router onto one shared output channel.
- Grants one FIFO at a time and holds the grant for a whole packet: header, payload, then parity.
- A stalled packet is aborted after a timeout, and the block raises a soft reset to the stalled FIFO.
- Sits downstream of the router FIFOs, alongside the router FSM and sync logic.

Parameters:
- WIDTH, 8, data byte width; header layout is [7:2] payload length, [1:0] address.
- TIMEOUT, 30, consecutive non-transfer cycles inside a packet before abort (range 2..255).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  3  per-FIFO empty flags, bit i = FIFO i.
- fifo_dout_0  in  WIDTH  head word of FIFO 0 (first-word-fall-through).
- fifo_dout_1  in  WIDTH  head word of FIFO 1.
- fifo_dout_2  in  WIDTH  head word of FIFO 2.
- out_ready  in  1  downstream accepts the beat this cycle.
- read_enb  out  3  pop strobe to FIFO i; one-hot or zero.
- out_data  out  WIDTH  muxed head word of the granted FIFO.
- out_valid  out  1  out_data is a valid beat.
- out_last  out  1  current beat is the parity byte.
- grant  out  3  one-hot granted FIFO; 0 in IDLE.
- soft_reset  out  3  one-cycle pulse to the FIFO whose packet timed out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high; it wins over every other event):
  - State returns to IDLE.
  - RR pointer = 2, so FIFO 0 has first priority.
  - All counters are cleared.
  - All outputs are 0.
  - Reset in mid-packet abandons the packet with no soft_reset.
- Transfer rule: beat = out_valid && out_ready, and read_enb[g] = beat.
  - out_valid = busy && !fifo_empty[g]; out_data = fifo_dout_g.
  - All of these are combinational from state, so data-to-output latency is 0 cycles.
- States: IDLE, HEADER, PAYLOAD, PARITY.
- IDLE:
  - Search order is ptr+1, ptr+2, ptr (mod 3); pick the first FIFO with !fifo_empty.
  - Register the grant and go to HEADER. No beat is issued in IDLE, so arbitration costs 1 cycle.
  - If all FIFOs are empty, stay in IDLE.
- HEADER:
  - On a beat, latch len = out_data[7:2] into a 6-bit counter.
  - If len == 0, go to PARITY; otherwise go to PAYLOAD.
- PAYLOAD:
  - Each beat decrements the counter.
  - The beat that takes the counter from 1 to 0 moves the state to PARITY.
- PARITY:
  - out_last = out_valid.
  - On a beat: ptr = granted index, grant cleared, state IDLE.
  - Back-to-back packets therefore have one idle cycle between them.
- Timeout counter (8-bit):
  - Clears on every beat and on entry to HEADER.
  - Increments in HEADER, PAYLOAD and PARITY on every cycle without a beat (either FIFO empty or out_ready low).
  - When it reaches TIMEOUT-1 without a beat:
    - soft_reset[g] pulses for one cycle on the next clock;
    - state goes to IDLE and ptr = g;
    - no read_enb is issued in that cycle.
- Stalls:
  - A FIFO going empty mid-packet stalls the packet; the grant is never switched mid-packet.
  - out_data is don't-care whenever out_valid = 0.
- Length wrap: len 63 gives 65 beats in total (header + 63 payload + parity). The counter does not wrap beyond that.

Optional Feature:
- Macro: ROUTER_ARB_PARITY_CHK_EN.
- When defined:
  - Adds output parity_err (1 bit).
  - A running XOR over the header and payload beats of the current packet is compared with the parity beat.
  - On a mismatch, parity_err pulses high for one cycle, in the cycle after the parity beat.
  - The XOR clears on entry to HEADER; parity_err resets to 0.
- When undefined: the port and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package router_pkg holds:
  - the state enum (IDLE, HEADER, PAYLOAD, PARITY);
  - localparams NPORT = 3, LEN_MSB = 7, LEN_LSB = 2;
  - the default timeout constant.
- One sub-module, router_rr_pick: combinational 3-way round-robin selector taking {req[2:0], ptr[1:0]} and returning one-hot pick plus a valid flag.

Test Plan:
- FIFO 1 only, header 8'h0D (len 3), out_ready = 1:
  - grant = 3'b010 one cycle after reset release;
  - then 5 consecutive beats with read_enb = 3'b010;
  - out_last on the 5th beat; busy drops on the next cycle.
- All FIFOs non-empty, each holding a len-0 packet:
  - grant order 001, 010, 100, 001;
  - each packet is 2 beats, with one idle cycle between packets.
- Len 2 packet on FIFO 2 with out_ready held low for 4 cycles after the header:
  - out_valid stays high and out_data stays stable;
  - no read_enb during the stall and no soft_reset.
- FIFO 0 empties after the header, TIMEOUT = 30:
  - soft_reset = 3'b001 for exactly one cycle, 30 cycles after the header beat;
  - state returns to IDLE, and FIFO 1 wins next if non-empty.
- Reset asserted mid-PAYLOAD on FIFO 1:
  - next cycle all outputs are 0 and no soft_reset;
  - after release, FIFO 0 has first priority.
- With ROUTER_ARB_PARITY_CHK_EN defined:
  - header 8'h05, payload 8'hAA, parity 8'hAF gives no error;
  - parity 8'h00 gives parity_err = 1 for one cycle after the parity beat.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router output arbiter slice.
package router_pkg;

  localparam int NPORT       = 3;
  localparam int LEN_MSB     = 7;
  localparam int LEN_LSB     = 2;
  localparam int TIMEOUT_DEF = 30;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_e;

  function automatic logic [1:0] onehot_idx(input logic [NPORT-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NPORT; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // (base + step) mod NPORT, valid for base < NPORT and step <= NPORT.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 3'(NPORT)) sum = sum - 3'(NPORT);
    return sum[1:0];
  endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// FIFO-side and output-channel signals of the router output arbiter.
interface router_out_arbiter_if #(parameter int WIDTH = 8);
  import router_pkg::*;

  logic [NPORT-1:0] fifo_empty;
  logic [WIDTH-1:0] fifo_dout_0;
  logic [WIDTH-1:0] fifo_dout_1;
  logic [WIDTH-1:0] fifo_dout_2;
  logic [NPORT-1:0] read_enb;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    input  fifo_empty, fifo_dout_0, fifo_dout_1, fifo_dout_2, out_ready,
    output read_enb, out_data, out_valid, out_last
  );

  modport slave (
    output fifo_empty, fifo_dout_0, fifo_dout_1, fifo_dout_2, out_ready,
    input  read_enb, out_data, out_valid, out_last
  );
endinterface

// File: rtl/router_rr_pick.sv
// Combinational 3-way round-robin selector: search order ptr+1, ptr+2, ptr.
module router_rr_pick
  import router_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [1:0]       ptr,
  output logic [NPORT-1:0] pick,
  output logic             valid
);

  logic [1:0] cand;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    cand  = ptr;
    for (int k = 1; k <= NPORT; k++) begin
      cand = rr_idx(ptr, 2'(k));
      if (!valid && req[cand]) begin
        pick[cand] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Round-robin packet scheduler draining three router FIFOs onto one output channel.
// Optional parity checking of each packet is enabled by defining ROUTER_ARB_PARITY_CHK_EN.
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
)(
  input  logic                 clock,
  input  logic                 reset,
  router_out_arbiter_if.master bus,
  output logic [NPORT-1:0]     grant,
  output logic [NPORT-1:0]     soft_reset,
  output logic                 busy
`ifdef ROUTER_ARB_PARITY_CHK_EN
  ,
  output logic                 parity_err
`endif
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [NPORT-1:0] grant_q, grant_d;
  logic [NPORT-1:0] srst_q, srst_d;
  logic [5:0]       len_q, len_d;
  logic [7:0]       to_q, to_d;
  logic [1:0]       g;
  logic [WIDTH-1:0] data;
  logic             valid, beat;
  logic [NPORT-1:0] pick;
  logic             pick_valid;

  router_rr_pick u_pick (
    .req   (~bus.fifo_empty),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Output channel is purely combinational from the registered grant and state.
  always_comb begin
    case (grant_q)
      3'b001:  data = bus.fifo_dout_0;
      3'b010:  data = bus.fifo_dout_1;
      3'b100:  data = bus.fifo_dout_2;
      default: data = '0;
    endcase
  end

  assign g     = onehot_idx(grant_q);
  assign busy  = (state_q != IDLE);
  assign valid = busy && !bus.fifo_empty[g];
  assign beat  = valid && bus.out_ready;

  assign bus.out_data  = data;
  assign bus.out_valid = valid;
  assign bus.out_last  = (state_q == PARITY) && valid;
  assign bus.read_enb  = grant_q & {NPORT{beat}};
  assign grant         = grant_q;
  assign soft_reset    = srst_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    len_d   = len_q;
    to_d    = to_q;
    srst_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          to_d    = 8'd0;
          state_d = HEADER;
        end
      end
      default: begin
        to_d = beat ? 8'd0 : to_q + 8'd1;
        if (!beat && (to_q == TO_LAST)) begin
          // Stalled too long: abandon the packet and flush the stuck FIFO.
          srst_d  = grant_q;
          ptr_d   = g;
          grant_d = '0;
          state_d = IDLE;
        end else if (beat) begin
          if (state_q == HEADER) begin
            len_d   = data[LEN_MSB:LEN_LSB];
            state_d = (len_d == 6'd0) ? PARITY : PAYLOAD;
          end else if (state_q == PAYLOAD) begin
            len_d = len_q - 6'd1;
            if (len_q == 6'd1) state_d = PARITY;
          end else begin
            ptr_d   = g;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd2;
      grant_q <= '0;
      srst_q  <= '0;
      len_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      srst_q  <= srst_d;
      len_q   <= len_d;
      to_q    <= to_d;
    end
  end

`ifdef ROUTER_ARB_PARITY_CHK_EN
  logic [WIDTH-1:0] xor_q, xor_d;
  logic             perr_q, perr_d;

  // HEADER is only entered from IDLE, so clearing while idle equals clearing on entry.
  always_comb begin
    xor_d  = xor_q;
    perr_d = 1'b0;
    if (state_q == IDLE) begin
      xor_d = '0;
    end else if (beat && (state_q != PARITY)) begin
      xor_d = xor_q ^ data;
    end else if (beat) begin
      perr_d = (xor_q != data);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xor_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      xor_q  <= xor_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_router_out_arbiter.sv
// Scoreboard bench for router_out_arbiter: FIFO models feed the DUT, expected beats are queued at load time.
module tb_router_out_arbiter;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] port;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       rdy;
  logic [2:0] grant, soft_reset;
  logic       busy;
`ifdef ROUTER_ARB_PARITY_CHK_EN
  logic       parity_err;
  logic       s_perr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  exp_t       exp_q[$];
  logic [7:0] fq0[$], fq1[$], fq2[$];

  logic [2:0] s_grant, s_rden, s_srst;
  logic [7:0] s_data;
  logic       s_busy, s_valid, s_last, s_beat;

  router_out_arbiter_if #(.WIDTH(8)) bus ();

  router_out_arbiter #(.WIDTH(8), .TIMEOUT(30)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.master),
    .grant      (grant),
    .soft_reset (soft_reset),
    .busy       (busy)
`ifdef ROUTER_ARB_PARITY_CHK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic drive();
    bus.fifo_empty  = {fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
    bus.fifo_dout_0 = (fq0.size() != 0) ? fq0[0] : 8'h00;
    bus.fifo_dout_1 = (fq1.size() != 0) ? fq1[0] : 8'h00;
    bus.fifo_dout_2 = (fq2.size() != 0) ? fq2[0] : 8'h00;
    bus.out_ready   = rdy;
  endtask

  task automatic push_byte(input int port, input logic [7:0] b);
    case (port)
      0:       fq0.push_back(b);
      1:       fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
  endtask

  // Loads one packet into FIFO 'port' and queues the beats it should produce.
  task automatic load_pkt(input int port, input int len, input logic [7:0] base, input logic bad_par);
    logic [7:0] b, par;
    b = {6'(len), 2'(port)};
    push_byte(port, b);
    exp_q.push_back('{data: b, last: 1'b0, port: 2'(port)});
    par = b;
    for (int j = 0; j < len; j++) begin
      b = base + 8'(j * 17);
      push_byte(port, b);
      exp_q.push_back('{data: b, last: 1'b0, port: 2'(port)});
      par = par ^ b;
    end
    if (bad_par) par = 8'h00;
    push_byte(port, par);
    exp_q.push_back('{data: par, last: 1'b1, port: 2'(port)});
    drive();
  endtask

  task automatic flush_models();
    fq0.delete();
    fq1.delete();
    fq2.delete();
    exp_q.delete();
  endtask

  // One clock: sample at negedge, score any beat, then update FIFO models after posedge.
  task automatic tick();
    exp_t       e;
    logic [7:0] dummy;
    @(negedge clock);
    s_grant = grant;
    s_busy  = busy;
    s_valid = bus.out_valid;
    s_data  = bus.out_data;
    s_last  = bus.out_last;
    s_rden  = bus.read_enb;
    s_srst  = soft_reset;
    s_beat  = bus.out_valid && bus.out_ready;
`ifdef ROUTER_ARB_PARITY_CHK_EN
    s_perr  = parity_err;
`endif
    n_checks++;
    if (s_beat === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_extra_beat: got data=%0h rden=%b, expected no beat", s_data, s_rden);
      end else begin
        e = exp_q.pop_front();
        if (s_data !== e.data || s_last !== e.last || s_rden !== (3'b001 << e.port)) begin
          n_errors++;
          $display("FAIL sb_beat: got data=%0h last=%b rden=%b, expected data=%0h last=%b rden=%b",
                   s_data, s_last, s_rden, e.data, e.last, 3'b001 << e.port);
        end
      end
    end else if (s_rden !== 3'b000) begin
      n_errors++;
      $display("FAIL rden_no_beat: got %b, expected 000", s_rden);
    end
    @(posedge clock);
    #1;
    if (s_rden[0] && fq0.size() != 0) dummy = fq0.pop_front();
    if (s_rden[1] && fq1.size() != 0) dummy = fq1.pop_front();
    if (s_rden[2] && fq2.size() != 0) dummy = fq2.pop_front();
    if (s_srst[0]) fq0.delete();
    if (s_srst[1]) fq1.delete();
    if (s_srst[2]) fq2.delete();
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rdy   = 1'b0;
    flush_models();
    drive();
    tick();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    rdy   = 1'b1;
    drive();
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d beats pending busy=%b, expected 0 pending busy=0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_checks++;
    if ({grant, soft_reset, busy, bus.out_valid, bus.out_last, bus.read_enb, bus.out_data} !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got grant=%b srst=%b busy=%b valid=%b last=%b rden=%b data=%0h, expected all 0",
               grant, soft_reset, busy, bus.out_valid, bus.out_last, bus.read_enb, bus.out_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    load_pkt(1, 3, 8'h11, 1'b0);
    release_reset();
    n_checks++;
    if (grant !== 3'b010) begin
      n_errors++;
      $display("FAIL single_grant: got %b, expected 010", grant);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (s_beat !== 1'b1 || s_rden !== 3'b010) begin
        n_errors++;
        $display("FAIL single_beat%0d: got beat=%b rden=%b, expected beat=1 rden=010", k, s_beat, s_rden);
      end
      n_checks++;
      if (s_last !== (k == 4)) begin
        n_errors++;
        $display("FAIL single_last%0d: got %b, expected %b", k, s_last, k == 4);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL single_busy_drop: got %b, expected 0", busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] ord [4];
    logic [2:0] exp_g;
    ord = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    load_pkt(0, 0, 8'h00, 1'b0);
    load_pkt(1, 0, 8'h00, 1'b0);
    load_pkt(2, 0, 8'h00, 1'b0);
    load_pkt(0, 0, 8'h00, 1'b0);
    release_reset();
    for (int c = 0; c < 12; c++) begin
      tick();
      exp_g = (c % 3 == 2) ? 3'b000 : ord[c / 3];
      n_checks++;
      if (s_grant !== exp_g || s_beat !== (c % 3 != 2)) begin
        n_errors++;
        $display("FAIL rr_cycle%0d: got grant=%b beat=%b, expected grant=%b beat=%b",
                 c, s_grant, s_beat, exp_g, c % 3 != 2);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rr_pending: got %0d beats left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    load_pkt(2, 2, 8'h11, 1'b0);
    release_reset();
    tick();
    n_checks++;
    if (s_beat !== 1'b1 || s_data !== 8'h0A) begin
      n_errors++;
      $display("FAIL stall_header: got beat=%b data=%0h, expected beat=1 data=0a", s_beat, s_data);
    end
    rdy = 1'b0;
    drive();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== 8'h11 || s_rden !== 3'b000 || s_srst !== 3'b000) begin
        n_errors++;
        $display("FAIL stall_hold%0d: got valid=%b data=%0h rden=%b srst=%b, expected valid=1 data=11 rden=000 srst=000",
                 k, s_valid, s_data, s_rden, s_srst);
      end
    end
    rdy = 1'b1;
    drive();
    wait_idle(20);
  endtask

  task automatic test_timeout();
    logic [2:0] exp_s;
    do_reset();
    push_byte(0, 8'h0C);
    exp_q.push_back('{data: 8'h0C, last: 1'b0, port: 2'd0});
    load_pkt(1, 0, 8'h00, 1'b0);
    release_reset();
    tick();
    n_checks++;
    if (s_beat !== 1'b1 || s_rden !== 3'b001) begin
      n_errors++;
      $display("FAIL to_header: got beat=%b rden=%b, expected beat=1 rden=001", s_beat, s_rden);
    end
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_s = (k == 31) ? 3'b001 : 3'b000;
      n_checks++;
      if (s_srst !== exp_s) begin
        n_errors++;
        $display("FAIL to_srst_k%0d: got %b, expected %b", k, s_srst, exp_s);
      end
      if (k == 31) begin
        n_checks++;
        if (s_busy !== 1'b0 || s_grant !== 3'b000) begin
          n_errors++;
          $display("FAIL to_idle: got busy=%b grant=%b, expected busy=0 grant=000", s_busy, s_grant);
        end
      end
      if (k == 32) begin
        n_checks++;
        if (s_grant !== 3'b010) begin
          n_errors++;
          $display("FAIL to_next_grant: got %b, expected 010", s_grant);
        end
      end
    end
    wait_idle(10);
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_pkt(1, 3, 8'h11, 1'b0);
    release_reset();
    tick();
    tick();
    reset = 1'b1;
    rdy   = 1'b0;
    drive();
    tick();
    n_checks++;
    if ({grant, soft_reset, busy, bus.out_valid, bus.out_last, bus.read_enb, bus.out_data} !== 20'h0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got grant=%b srst=%b busy=%b valid=%b last=%b rden=%b data=%0h, expected all 0",
               grant, soft_reset, busy, bus.out_valid, bus.out_last, bus.read_enb, bus.out_data);
    end
    flush_models();
    load_pkt(0, 0, 8'h00, 1'b0);
    load_pkt(1, 0, 8'h00, 1'b0);
    tick();
    n_checks++;
    if (s_srst !== 3'b000) begin
      n_errors++;
      $display("FAIL midreset_srst: got %b, expected 000", s_srst);
    end
    release_reset();
    n_checks++;
    if (grant !== 3'b001) begin
      n_errors++;
      $display("FAIL midreset_priority: got %b, expected 001", grant);
    end
    wait_idle(20);
  endtask

`ifdef ROUTER_ARB_PARITY_CHK_EN
  task automatic run_parity_pkt(input logic bad, input string name);
    logic exp_err;
    int   n;
    exp_err = bad ? ((8'h05 ^ 8'hAA) != 8'h00) : 1'b0;
    load_pkt(1, 1, 8'hAA, bad);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(s_beat === 1'b1 && s_last === 1'b1) && n < 20);
    tick();
    n_checks++;
    if (s_perr !== exp_err) begin
      n_errors++;
      $display("FAIL %s_err: got %b, expected %b", name, s_perr, exp_err);
    end
    tick();
    n_checks++;
    if (s_perr !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_err_pulse: got %b, expected 0", name, s_perr);
    end
  endtask

  task automatic test_parity();
    do_reset();
    release_reset();
    run_parity_pkt(1'b0, "parity_good");
    run_parity_pkt(1'b1, "parity_bad");
    wait_idle(10);
  endtask
`endif

  initial begin
    reset = 1'b1;
    rdy   = 1'b0;
    drive();
    @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_timeout();
    test_reset_mid();
`ifdef ROUTER_ARB_PARITY_CHK_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
